// File: rtl/msdap_serial_deserializer.sv
`default_nettype none
// ============================================================================
// | Module   : msdap_serial_deserializer                                     |
// | Purpose  : Converts the MSDAP framed serial stereo input (MSB first) to  |
// |            WIDTH-bit parallel left/right words. Runs in the system-clock |
// |            domain; upstream logic supplies a one-cycle bit strobe and a  |
// |            frame marker that is qualified by that strobe.                |
// | Optional : MSDAP_DESER_ERR_EN enables framing-error detection           |
// |            (frame_err pulse + saturating err_count). When it is not     |
// |            defined, both ports are tied to 0.                            |
// | Ports    :                                                               |
// |   clk        in   1          system clock, posedge                       |
// |   rst_n      in   1          synchronous active-low reset                |
// |   bit_en     in   1          one-cycle sampling strobe                   |
// |   frame      in   1          MSB marker, qualified by bit_en             |
// |   in_l       in   1          left-channel serial bit                     |
// |   in_r       in   1          right-channel serial bit                    |
// |   data_l     out  WIDTH      last completed left word                    |
// |   data_r     out  WIDTH      last completed right word                   |
// |   data_valid out  1          one-cycle pulse when data_l/data_r update   |
// |   busy       out  1          high while a word is being assembled        |
// |   frame_err  out  1          one-cycle pulse on early frame              |
// |   err_count  out  ERR_CNT_W  saturating early-frame count                |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module msdap_serial_deserializer #(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_en,
   input  logic                 frame,
   input  logic                 in_l,
   input  logic                 in_r,
   output logic [WIDTH-1:0]     data_l,
   output logic [WIDTH-1:0]     data_r,
   output logic                 data_valid,
   output logic                 busy,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [WIDTH-1:0] r_sh_l;
   logic [WIDTH-1:0] r_sh_r;
   logic [WIDTH-1:0] r_data_l;
   logic [WIDTH-1:0] r_data_r;
   logic             r_data_valid;

   logic [WIDTH-1:0] w_sh_l_next;
   logic [WIDTH-1:0] w_sh_r_next;
   logic             w_last_bit;

   assign w_sh_l_next = {r_sh_l[WIDTH-2:0], in_l};
   assign w_sh_r_next = {r_sh_r[WIDTH-2:0], in_r};
   // The capture in progress is bit number WIDTH of the word.
   assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_sh_l       <= '0;
         r_sh_r       <= '0;
         r_data_l     <= '0;
         r_data_r     <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         if (bit_en) begin
            if (frame) begin
               // New word starts here, whether from IDLE or as a resync
               // that drops a partial word. Clearing the stale bits keeps
               // the shift registers meaningful while assembling.
               r_state   <= S_SHIFT;
               r_bit_cnt <= CNT_W'(1);
               r_sh_l    <= {{(WIDTH-1){1'b0}}, in_l};
               r_sh_r    <= {{(WIDTH-1){1'b0}}, in_r};
            end else if (r_state == S_SHIFT) begin
               r_sh_l <= w_sh_l_next;
               r_sh_r <= w_sh_r_next;
               if (w_last_bit) begin
                  r_data_l     <= w_sh_l_next;
                  r_data_r     <= w_sh_r_next;
                  r_data_valid <= 1'b1;
                  r_bit_cnt    <= '0;
                  r_state      <= S_IDLE;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   assign data_l     = r_data_l;
   assign data_r     = r_data_r;
   assign data_valid = r_data_valid;
   assign busy       = (r_state == S_SHIFT);

`ifdef MSDAP_DESER_ERR_EN
   logic                 r_frame_err;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic                 w_early_frame;

   // A framed strobe while a word is still being assembled.
   assign w_early_frame = bit_en & frame & (r_state == S_SHIFT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_frame_err <= w_early_frame;
         if (w_early_frame && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
         end
      end
   end

   assign frame_err = r_frame_err;
   assign err_count = r_err_count;
`else
   assign frame_err = 1'b0;
   assign err_count = '0;
`endif

endmodule
`default_nettype wire
